// File: rtl/pool_stream_framer.sv
// Frames pooled 2x2 feature-map beats into an AXI-Stream with TLAST, completion pulse,
// beat counting and an upstream-last cross-check, behind a 2-entry registered skid buffer.
module pool_stream_framer #(
    parameter int unsigned DATA_WIDTH            = 256,
    parameter int unsigned WIDTH_CHANNEL_NUM_REG = 10,
    parameter int unsigned WIDTH_FEATURE_SIZE    = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Next_Reg,
    input  logic                            Start,
    input  logic [WIDTH_FEATURE_SIZE-1:0]   Row_Num_Out_REG,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
    input  logic [DATA_WIDTH-1:0]           S_Data,
    input  logic                            S_Valid,
    output logic                            S_Ready,
    input  logic                            S_Last,
    output logic [DATA_WIDTH-1:0]           M_Data,
    output logic                            M_Valid,
    input  logic                            M_Ready,
    output logic                            M_Last,
    output logic                            Stream_Complete,
    output logic                            Last_Mismatch,
    output logic [WIDTH_FEATURE_SIZE*2-1:0] Beat_Count
);

    localparam int unsigned CW = WIDTH_CHANNEL_NUM_REG - 4;
    localparam int unsigned PW = WIDTH_FEATURE_SIZE - 1;
    localparam int unsigned BW = WIDTH_FEATURE_SIZE * 2;
    localparam logic [CW:0] OneC = (CW + 1)'(1);
    localparam logic [PW:0] OneP = (PW + 1)'(1);
    localparam logic [BW-1:0] OneB = BW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_cout_q, cnt_cout_d;
    logic [PW-1:0]   cnt_col_q, cnt_col_d;
    logic [PW-1:0]   cnt_row_q, cnt_row_d;
    logic [DATA_WIDTH-1:0] buf0_data_q, buf0_data_d, buf1_data_q, buf1_data_d;
    logic            buf0_last_q, buf0_last_d, buf1_last_q, buf1_last_d;
    logic            buf0_vld_q, buf0_vld_d, buf1_vld_q, buf1_vld_d;
    logic            s_ready_q, s_ready_d;
    logic            complete_q, complete_d;
    logic            mismatch_q, mismatch_d;
    logic [BW-1:0]   beat_q, beat_d;

    logic [CW-1:0]   c_lim;
    logic [PW-1:0]   p_lim;
    logic            zero_size, cout_max, col_max, row_max, is_final, push, pop;

    assign c_lim     = Channel_Out_Num_REG[WIDTH_CHANNEL_NUM_REG-1:4];
    assign p_lim     = Row_Num_Out_REG[WIDTH_FEATURE_SIZE-1:1];
    assign zero_size = (c_lim == '0) || (p_lim == '0);
    assign cout_max  = (({1'b0, cnt_cout_q} + OneC) == {1'b0, c_lim});
    assign col_max   = (({1'b0, cnt_col_q} + OneP) == {1'b0, p_lim});
    assign row_max   = (({1'b0, cnt_row_q} + OneP) == {1'b0, p_lim});
    assign is_final  = cout_max && col_max && row_max;
    assign push      = S_Valid && s_ready_q;
    assign pop       = buf0_vld_q && M_Ready;

    always_comb begin
        state_d     = state_q;
        cnt_cout_d  = cnt_cout_q;
        cnt_col_d   = cnt_col_q;
        cnt_row_d   = cnt_row_q;
        buf0_data_d = buf0_data_q;
        buf1_data_d = buf1_data_q;
        buf0_last_d = buf0_last_q;
        buf1_last_d = buf1_last_q;
        buf0_vld_d  = buf0_vld_q;
        buf1_vld_d  = buf1_vld_q;
        mismatch_d  = mismatch_q;
        beat_d      = beat_q;

        if (pop) begin
            beat_d = beat_q + OneB;
        end

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    beat_d     = '0;
                    cnt_cout_d = '0;
                    cnt_col_d  = '0;
                    cnt_row_d  = '0;
                    state_d    = zero_size ? StDone : StRun;
                end
            end
            StRun: begin
                if (push) begin
                    if (cout_max) begin
                        cnt_cout_d = '0;
                        if (col_max) begin
                            cnt_col_d = '0;
                            cnt_row_d = row_max ? '0 : cnt_row_q + 1'b1;
                        end else begin
                            cnt_col_d = cnt_col_q + 1'b1;
                        end
                    end else begin
                        cnt_cout_d = cnt_cout_q + 1'b1;
                    end
                    if (S_Last != is_final) begin
                        mismatch_d = 1'b1;
                    end
                    if (is_final) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && buf0_last_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Pop shifts the tail forward first, then a push fills the first free slot,
        // so a simultaneous push/pop keeps both occupancy and order.
        if (pop) begin
            buf0_data_d = buf1_data_q;
            buf0_last_d = buf1_last_q;
            buf0_vld_d  = buf1_vld_q;
            buf1_vld_d  = 1'b0;
        end
        if (push) begin
            if (!buf0_vld_d) begin
                buf0_data_d = S_Data;
                buf0_last_d = is_final;
                buf0_vld_d  = 1'b1;
            end else begin
                buf1_data_d = S_Data;
                buf1_last_d = is_final;
                buf1_vld_d  = 1'b1;
            end
        end

        s_ready_d  = (state_d == StRun) && !buf1_vld_d;
        complete_d = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst || Next_Reg) begin
            state_q     <= StIdle;
            cnt_cout_q  <= '0;
            cnt_col_q   <= '0;
            cnt_row_q   <= '0;
            buf0_data_q <= '0;
            buf1_data_q <= '0;
            buf0_last_q <= 1'b0;
            buf1_last_q <= 1'b0;
            buf0_vld_q  <= 1'b0;
            buf1_vld_q  <= 1'b0;
            s_ready_q   <= 1'b0;
            complete_q  <= 1'b0;
            mismatch_q  <= 1'b0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_cout_q  <= cnt_cout_d;
            cnt_col_q   <= cnt_col_d;
            cnt_row_q   <= cnt_row_d;
            buf0_data_q <= buf0_data_d;
            buf1_data_q <= buf1_data_d;
            buf0_last_q <= buf0_last_d;
            buf1_last_q <= buf1_last_d;
            buf0_vld_q  <= buf0_vld_d;
            buf1_vld_q  <= buf1_vld_d;
            s_ready_q   <= s_ready_d;
            complete_q  <= complete_d;
            mismatch_q  <= mismatch_d;
            beat_q      <= beat_d;
        end
    end

    assign S_Ready         = s_ready_q;
    assign M_Data          = buf0_data_q;
    assign M_Valid         = buf0_vld_q;
    assign M_Last          = buf0_last_q;
    assign Stream_Complete = complete_q;
    assign Last_Mismatch   = mismatch_q;
    assign Beat_Count      = beat_q;

endmodule

// File: tb/tb_pool_stream_framer.sv
// Directed bench for pool_stream_framer: scoreboard of accepted input beats checked
// against every output beat, plus layer-level checks of count, completion and mismatch.
module tb_pool_stream_framer;

    localparam int unsigned DW  = 256;
    localparam int unsigned WCH = 10;
    localparam int unsigned WFS = 11;

    logic            clk = 1'b0;
    logic            rst, Next_Reg, Start, S_Valid, S_Last, M_Ready;
    logic [WFS-1:0]  Row_Num_Out_REG;
    logic [WCH-1:0]  Channel_Out_Num_REG;
    logic [DW-1:0]   S_Data, M_Data;
    logic            S_Ready, M_Valid, M_Last, Stream_Complete, Last_Mismatch;
    logic [2*WFS-1:0] Beat_Count;

    pool_stream_framer #(
        .DATA_WIDTH           (DW),
        .WIDTH_CHANNEL_NUM_REG(WCH),
        .WIDTH_FEATURE_SIZE   (WFS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .Next_Reg           (Next_Reg),
        .Start              (Start),
        .Row_Num_Out_REG    (Row_Num_Out_REG),
        .Channel_Out_Num_REG(Channel_Out_Num_REG),
        .S_Data             (S_Data),
        .S_Valid            (S_Valid),
        .S_Ready            (S_Ready),
        .S_Last             (S_Last),
        .M_Data             (M_Data),
        .M_Valid            (M_Valid),
        .M_Ready            (M_Ready),
        .M_Last             (M_Last),
        .Stream_Complete    (Stream_Complete),
        .Last_Mismatch      (Last_Mismatch),
        .Beat_Count         (Beat_Count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, in_cnt = 0, out_cnt = 0, n_total = 0;
    int   last_out_cyc = -1, comp_cyc = -1, comp_pulses = 0;
    bit   in_hs = 0, seen_full = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: observe at the falling edge, update the scoreboard, then step past posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        in_hs = 1'b0;
        if (Stream_Complete) begin
            comp_pulses++;
            comp_cyc = cyc;
        end
        if (!rst && !Next_Reg) begin
            chk1("m_valid", M_Valid, sb.size() != 0);
            if (sb.size() == 2) begin
                seen_full = 1'b1;
                chk1("s_ready_full", S_Ready, 1'b0);
            end
            if (M_Valid && sb.size() != 0) begin
                chkw("m_data", M_Data, sb[0].data);
                chk1("m_last", M_Last, sb[0].last);
                if (M_Ready) begin
                    void'(sb.pop_front());
                    out_cnt++;
                    if (M_Last) last_out_cyc = cyc;
                end
            end
            if (S_Valid && S_Ready) begin
                e.data = S_Data;
                e.last = (in_cnt == n_total - 1);
                sb.push_back(e);
                in_cnt++;
                in_hs = 1'b1;
            end
        end else begin
            sb.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_layer(input int row, input int ch);
        n_total = (row >> 1) * (row >> 1) * (ch >> 4);
        in_cnt = 0; out_cnt = 0; comp_pulses = 0; last_out_cyc = -1; comp_cyc = -1;
        Row_Num_Out_REG     = WFS'(row);
        Channel_Out_Num_REG = WCH'(ch);
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic run_layer(input int row, input int ch, input int last_pos,
                             input logic [3:0] pat, input logic exp_mismatch);
        int budget;
        start_layer(row, ch);
        S_Valid = 1'b1;
        S_Data  = rand_beat();
        S_Last  = (last_pos == 0);
        budget  = 0;
        while ((out_cnt < n_total || comp_pulses == 0) && budget < 300) begin
            M_Ready = pat[budget % 4];
            tick();
            budget++;
            if (in_hs) begin
                if (in_cnt < n_total) begin
                    S_Data = rand_beat();
                    S_Last = (in_cnt == last_pos);
                end else begin
                    S_Valid = 1'b0;
                    S_Last  = 1'b0;
                end
            end
        end
        S_Valid = 1'b0;
        M_Ready = 1'b1;
        tick();
        tick();
        chk1("layer_in_budget", budget < 300, 1'b1);
        chkw("out_beats", DW'(out_cnt), DW'(n_total));
        chkw("beat_count", DW'(Beat_Count), DW'(n_total));
        chkw("complete_pulses", DW'(comp_pulses), DW'(1));
        chkw("complete_latency", DW'(comp_cyc - last_out_cyc), DW'(2));
        chk1("last_mismatch", Last_Mismatch, exp_mismatch);
    endtask

    initial begin
        int budget;
        rst = 1'b1; Next_Reg = 1'b0; Start = 1'b0; S_Valid = 1'b0; S_Last = 1'b0;
        M_Ready = 1'b1; S_Data = '0; Row_Num_Out_REG = '0; Channel_Out_Num_REG = '0;
        tick();
        tick();
        rst = 1'b0;
        chk1("rst_s_ready", S_Ready, 1'b0);
        chk1("rst_m_valid", M_Valid, 1'b0);
        chk1("rst_m_last", M_Last, 1'b0);
        chkw("rst_m_data", M_Data, '0);
        chk1("rst_complete", Stream_Complete, 1'b0);
        chk1("rst_mismatch", Last_Mismatch, 1'b0);
        chkw("rst_beat_count", DW'(Beat_Count), '0);

        // Basic framing and backpressure: P=2, C=2 -> 8 beats.
        run_layer(4, 32, 7, 4'b1111, 1'b0);
        seen_full = 1'b0;
        run_layer(4, 32, 7, 4'b1001, 1'b0);
        chk1("backpressure_filled", seen_full, 1'b1);

        // Early last, then missing last (sticky flag cleared by Next_Reg between them).
        run_layer(4, 16, 1, 4'b1111, 1'b1);
        Next_Reg = 1'b1;
        tick();
        Next_Reg = 1'b0;
        chk1("next_reg_clears_mismatch", Last_Mismatch, 1'b0);
        run_layer(4, 16, -1, 4'b1111, 1'b1);

        // Zero-size layer: Beat_Count was 4 and must clear on Start.
        start_layer(1, 16);
        S_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("zero_s_ready", S_Ready, 1'b0);
        end
        S_Valid = 1'b0;
        chkw("zero_complete", DW'(comp_pulses), DW'(1));
        chkw("zero_beat_count", DW'(Beat_Count), '0);

        // Mid-layer abort after 5 beats with 2 buffered, then a fresh 4-beat layer.
        start_layer(8, 16);
        S_Valid = 1'b1;
        S_Data  = rand_beat();
        S_Last  = 1'b0;
        budget  = 0;
        while (!(in_cnt == 5 && sb.size() == 2) && budget < 50) begin
            M_Ready = (out_cnt < 3);
            tick();
            budget++;
            if (in_hs) S_Data = rand_beat();
        end
        chk1("abort_reached", budget < 50, 1'b1);
        Next_Reg = 1'b1;
        tick();
        Next_Reg = 1'b0;
        S_Valid  = 1'b0;
        M_Ready  = 1'b1;
        chk1("abort_m_valid", M_Valid, 1'b0);
        chk1("abort_s_ready", S_Ready, 1'b0);
        chkw("abort_beat_count", DW'(Beat_Count), '0);
        tick();
        run_layer(4, 16, 3, 4'b1111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
